jk_input_conditioner: RTL and testbench

JK_INPUT_CONDITIONER -- requirements
Module: jk_input_conditioner

---
 rtl/jk_input_conditioner.sv | 110 +++++++++++
 tb/tb_jk_input_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_input_conditioner.sv
// ============================================================================
// Module   : jk_input_conditioner
// Summary  : Synchronises and debounces raw J/K switches and latches the {J,K}
//            command on a divided clock-enable tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_input_conditioner #(
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_DIV   = 33554432
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       j_raw,
  input  logic       k_raw,
  output logic       j_out,
  output logic       k_out,
  output logic       j_rise,
  output logic       k_rise,
  output logic       tick,
  output logic [1:0] jk_cmd,
  output logic       cmd_valid
);

  localparam int c_deb_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_deb_w-1:0] c_deb_max = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(TICK_DIV - 1);

  // Channel index 1 carries J, index 0 carries K.
  logic [1:0]         w_raw;
  logic [1:0]         r_meta;
  logic [1:0]         r_sync;
  logic [1:0]         r_out;
  logic [1:0]         r_rise;
  logic [c_deb_w-1:0] r_cnt [2];
  logic [1:0]         w_load;

  logic [c_div_w-1:0] r_div_cnt;
  logic               w_tick;
  logic [1:0]         r_jk_cmd;
  logic               r_cmd_valid;

  assign w_raw = {j_raw, k_raw};

  always_comb begin
    w_load = '0;
    for (int i = 0; i < 2; i++) begin
      w_load[i] = (r_sync[i] != r_out[i]) && (r_cnt[i] == c_deb_max);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_out  <= '0;
      r_rise <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        // Any agreement between synchronised input and output restarts the hold.
        if (r_sync[i] == r_out[i]) begin
          r_cnt[i] <= '0;
        end else if (w_load[i]) begin
          r_out[i] <= r_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_deb_w'(1);
        end
        r_rise[i] <= w_load[i] & r_sync[i];
      end
    end
  end

  assign w_tick = (r_div_cnt == c_div_max);

  // Capture samples the pre-edge debounced levels, so a same-edge change waits a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_jk_cmd    <= 2'b00;
      r_cmd_valid <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_jk_cmd  <= r_out;
      end else begin
        r_div_cnt <= r_div_cnt + c_div_w'(1);
      end
      r_cmd_valid <= w_tick;
    end
  end

  assign j_out     = r_out[1];
  assign k_out     = r_out[0];
  assign j_rise    = r_rise[1];
  assign k_rise    = r_rise[0];
  assign tick      = w_tick;
  assign jk_cmd    = r_jk_cmd;
  assign cmd_valid = r_cmd_valid;

endmodule

`default_nettype wire

// File: tb/tb_jk_input_conditioner.sv
// ============================================================================
// Module   : tb_jk_input_conditioner
// Summary  : Directed bench for jk_input_conditioner (DEB_CYCLES=4 with
//            TICK_DIV=8 and TICK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_input_conditioner;

  logic       clk;
  logic       reset;
  logic       j_raw;
  logic       k_raw;
  logic       j_out, k_out, j_rise, k_rise, tick, cmd_valid;
  logic [1:0] jk_cmd;
  logic       j_out1, k_out1, j_rise1, k_rise1, tick1, cmd_valid1;
  logic [1:0] jk_cmd1;

  int checks;
  int errors;

  jk_input_conditioner #(.DEB_CYCLES(4), .TICK_DIV(8)) dut (
    .clk(clk), .reset(reset), .j_raw(j_raw), .k_raw(k_raw),
    .j_out(j_out), .k_out(k_out), .j_rise(j_rise), .k_rise(k_rise),
    .tick(tick), .jk_cmd(jk_cmd), .cmd_valid(cmd_valid)
  );

  jk_input_conditioner #(.DEB_CYCLES(4), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .j_raw(j_raw), .k_raw(k_raw),
    .j_out(j_out1), .k_out(k_out1), .j_rise(j_rise1), .k_rise(k_rise1),
    .tick(tick1), .jk_cmd(jk_cmd1), .cmd_valid(cmd_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1ns into cycle 0 (before the first active edge).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    j_raw = 1'b0;
    k_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    j_raw = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (j_out !== 1'b1 || jk_cmd !== 2'b10) begin
      errors++;
      $display("FAIL reset_precond: j_out=%b jk_cmd=%b required j_out=1 jk_cmd=10", j_out, jk_cmd);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({j_out, k_out, j_rise, k_rise, tick, jk_cmd, cmd_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_async: outs=%b required 00000000",
               {j_out, k_out, j_rise, k_rise, tick, jk_cmd, cmd_valid});
    end
    checks++;
    if ({j_out1, k_out1, j_rise1, k_rise1, tick1, jk_cmd1, cmd_valid1} !== 8'b00001000) begin
      errors++;
      $display("FAIL reset_async_div1: outs=%b required 00001000",
               {j_out1, k_out1, j_rise1, k_rise1, tick1, jk_cmd1, cmd_valid1});
    end
    @(negedge clk);
  endtask

  task automatic test_tick_cadence();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      checks++;
      if (tick !== ((c % 8) == 7)) begin
        errors++;
        $display("FAIL tick_cadence c=%0d: tick=%b required %b", c, tick, ((c % 8) == 7));
      end
      checks++;
      if (cmd_valid !== (c > 0 && (c % 8) == 0) || jk_cmd !== 2'b00) begin
        errors++;
        $display("FAIL idle_cmd c=%0d: cmd_valid=%b jk_cmd=%b required %b 00",
                 c, cmd_valid, jk_cmd, (c > 0 && (c % 8) == 0));
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    j_raw = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      #1;
      checks++;
      if (j_out !== (n >= 6) || j_rise !== (n == 6) || k_out !== 1'b0 || k_rise !== 1'b0) begin
        errors++;
        $display("FAIL clean_press n=%0d: j_out=%b j_rise=%b k_out=%b k_rise=%b required %b %b 0 0",
                 n, j_out, j_rise, k_out, k_rise, (n >= 6), (n == 6));
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      j_raw = ((i / 2) % 2) == 0;
      @(negedge clk);
      #1;
      checks++;
      if (j_out !== 1'b0 || j_rise !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold i=%0d: j_out=%b j_rise=%b required 0 0", i, j_out, j_rise);
      end
    end
    j_raw = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      #1;
      checks++;
      if (j_out !== (n >= 6) || j_rise !== (n == 6)) begin
        errors++;
        $display("FAIL bounce_settle n=%0d: j_out=%b j_rise=%b required %b %b",
                 n, j_out, j_rise, (n >= 6), (n == 6));
      end
    end
  endtask

  // Both pressed in cycle 0; K released in cycle 10 so k_out falls at the capture edge 16.
  task automatic test_capture();
    logic [1:0] exp_cmd;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      if (c == 0) begin
        j_raw = 1'b1;
        k_raw = 1'b1;
      end
      if (c == 10) k_raw = 1'b0;
      #1;
      exp_cmd = (c < 8) ? 2'b00 : (c < 24) ? 2'b11 : 2'b10;
      checks++;
      if (jk_cmd !== exp_cmd || cmd_valid !== (c == 8 || c == 16 || c == 24)) begin
        errors++;
        $display("FAIL capture c=%0d: jk_cmd=%b cmd_valid=%b required %b %b",
                 c, jk_cmd, cmd_valid, exp_cmd, (c == 8 || c == 16 || c == 24));
      end
      checks++;
      if (j_out !== (c >= 6) || k_out !== (c >= 6 && c < 16)) begin
        errors++;
        $display("FAIL capture_levels c=%0d: j_out=%b k_out=%b required %b %b",
                 c, j_out, k_out, (c >= 6), (c >= 6 && c < 16));
      end
      @(negedge clk);
    end
  endtask

  // J pressed cycle 0 (up from 6); K pressed cycle 2 (up 8..14), released cycle 9.
  task automatic test_div1();
    logic ej, ek;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 0) j_raw = 1'b1;
      if (c == 2) k_raw = 1'b1;
      if (c == 9) k_raw = 1'b0;
      #1;
      ej = (c - 1) >= 6;
      ek = ((c - 1) >= 8) && ((c - 1) <= 14);
      checks++;
      if (tick1 !== 1'b1 || cmd_valid1 !== (c >= 1)) begin
        errors++;
        $display("FAIL div1_tick c=%0d: tick=%b cmd_valid=%b required 1 %b", c, tick1, cmd_valid1, (c >= 1));
      end
      checks++;
      if (jk_cmd1 !== {ej, ek}) begin
        errors++;
        $display("FAIL div1_cmd c=%0d: jk_cmd=%b required %b", c, jk_cmd1, {ej, ek});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    j_raw  = 1'b0;
    k_raw  = 1'b0;
    test_reset();
    test_tick_cadence();
    test_clean_press();
    test_bounce();
    test_capture();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
